ub_affine_sched_ctrl: RTL and testbench
=======================================

// Module: ub_affine_sched_ctrl
// PURPOSE
//  Affine loop-nest schedule generator for one unified-buffer port (write or read).
//  Walks a 3-deep iteration domain and fires each point at
//  T = start + d0*S0 + d1*S1 + d2*S2 cycles after flush.
//  On each fire it drives the port's wen/ren and ctrl_vars[2:0].
//  One instance per buffer port; e.g. the hw_input write and the mult read of a 64x64 buffer.
// PARAMETERS
//  CW  16  width of ctrl_vars, extents and strides
//  TW  32  width of cycle counter and schedule-time accumulators
// PORTS
//  clk          in   1      clock; single clock domain
//  rst_n        in   1      asynchronous reset, active-low
//  flush        in   1      sync start/restart; latches cfg_*
//  stall        in   1      freezes schedule time; no fire while high
//  cfg_start    in   TW     cycle offset of first iteration
//  cfg_extent   in   CW x3  [0]=outermost .. [2]=innermost trip count
//  cfg_stride   in   CW x3  cycles added per increment of d0/d1/d2
//  en           out  1      port wen/ren strobe, one cycle per iteration
//  ctrl_vars    out  CW x3  {d0,d1,d2}; valid when en=1, holds last value otherwise
//  done         out  1      whole domain issued; held until flush/rst
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; en=0, ctrl_vars=0, done=0, counters=0.
//  - States: IDLE -> (flush) WAIT -> RUN -> DONE. flush from any state -> WAIT.
//  - IDLE: no fires and done=0 until the first flush.
//  - Cycle 0 is the cycle after the edge that samples flush=1.
//  - Time base: cycle counter t (TW bits) starts at 0 and increments each non-stalled cycle.
//  - Config: cfg_* are captured at flush. Changes while not flushing are ignored.
//  - Fire rule: en=1 in the cycle where t == next_time and stall=0.
//    - en, ctrl_vars and done are registered outputs, aligned to that cycle; zero extra latency.
//    - First fire: next_time=cfg_start, ctrl_vars=0.
//  - Advance after each fire (odometer, innermost first):
//    - d2+1. If d2==E2-1 then d2=0 and d1+1. If d1==E1-1 then d1=0 and d0+1.
//    - Times are kept incrementally in per-level base registers; no multipliers.
//  - Monotonic clamp: if the computed next time is <= the current fire time, fire next cycle instead.
//    - Covers zero or degenerate strides. The iteration count is never reduced.
//  - Last point (E0-1,E1-1,E2-1) fired: done=1 from the next cycle, state DONE, en=0 thereafter.
//  - Any extent==0: empty domain. No fire; done=1 in cycle 0.
//  - stall=1: t frozen, en forced 0. The pending fire happens on the first non-stalled cycle t==next_time.
//  - flush while RUN: abort and restart at cycle 0 with the new config. No en in the flush cycle.
//  - rst_n low mid-run: immediate return to reset values and state IDLE.
//  - Arithmetic is unsigned, modulo 2^TW. Schedules exceeding 2^TW-1 are unsupported.
// TESTING
//  1. E=(1,4,4), S=(0,4,1), start=2, flush -> en cycles 2..17 contiguous;
//     ctrl_vars (0,0,0),(0,0,1)..(0,3,3); done=1 at cycle 18.
//  2. E=(1,2,3), S=(0,10,3), start=0 -> fires at 0,3,6,10,13,16 with the matching
//     d1,d2; exactly 6 en pulses.
//  3. E=(1,1,3), S=(0,0,0), start=5 -> clamp: fires at 5,6,7; done at 8.
//  4. E2=0 -> no en ever; done=1 at cycle 0.
//  5. Case 1 with stall=1 for cycles 6..8 -> en gap of 3 cycles.
//     Remaining 12 fires are shifted by 3; sequence unchanged.
//  6. Flush at cycle 9 of case 1 -> restart from (0,0,0) at new cycle 2.
//     rst_n=0 mid-run -> en=0, ctrl_vars=0, done=0 immediately; IDLE until flush.

Source files
------------

// File: rtl/ub_affine_sched_ctrl_if.sv
// ub_affine_sched_ctrl_if: schedule-controller port bundle.
// master drives flush/stall/cfg_*; slave (the controller) drives en/ctrl_vars/done.
// cfg_extent/cfg_stride index [0]=outermost .. [2]=innermost; ctrl_vars is {d0,d1,d2}.
interface ub_affine_sched_ctrl_if #(
    parameter int CW = 16,
    parameter int TW = 32
);
    logic                flush;
    logic                stall;
    logic [TW-1:0]       cfg_start;
    logic [2:0][CW-1:0]  cfg_extent;
    logic [2:0][CW-1:0]  cfg_stride;
    logic                en;
    logic [3*CW-1:0]     ctrl_vars;
    logic                done;

    modport master (
        output flush, stall, cfg_start, cfg_extent, cfg_stride,
        input  en, ctrl_vars, done
    );

    modport slave (
        input  flush, stall, cfg_start, cfg_extent, cfg_stride,
        output en, ctrl_vars, done
    );
endinterface

// File: rtl/ub_affine_sched_ctrl.sv
// ub_affine_sched_ctrl: affine 3-deep loop-nest schedule generator for one unified-buffer port.
// Ports: clk, rst_n (async active-low), bus (slave modport: flush, stall, cfg_start,
// cfg_extent, cfg_stride in; en, ctrl_vars {d0,d1,d2}, done out).
// Inputs sampled on an edge govern the cycle that edge begins; en/ctrl_vars/done are registered.
module ub_affine_sched_ctrl #(
    parameter int CW = 16,
    parameter int TW = 32
) (
    input logic                     clk,
    input logic                     rst_n,
    ub_affine_sched_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RUN, DONE} state_t;

    state_t             state;
    logic [2:0][CW-1:0] ext, str;
    logic [CW-1:0]      d0, d1, d2;
    logic [TW-1:0]      t, nt, r, b0, b1;
    logic               stl, en_q, done_q;
    logic [3*CW-1:0]    vars_q;

    logic               l0, l1, l2, last, active, empty, fire;
    logic [TW-1:0]      s0, s1, s2, nb0, nb1, nr, nnt, tn;
    logic [TW-1:0]      cb0, cb1, cr, cnt;
    logic [CW-1:0]      cd0, cd1, cd2;

    assign l2 = d2 == ext[2] - CW'(1);
    assign l1 = d1 == ext[1] - CW'(1);
    assign l0 = d0 == ext[0] - CW'(1);
    assign last = l0 && l1 && l2;
    assign s0 = TW'(str[0]);
    assign s1 = TW'(str[1]);
    assign s2 = TW'(str[2]);
    // Odometer step: b0 = time of (d0,0,0), b1 = time of (d0,d1,0), r = unclamped time of the point.
    assign nb0 = (l2 && l1) ? b0 + s0 : b0;
    assign nb1 = !l2 ? b1 : !l1 ? b1 + s1 : b0 + s0;
    assign nr = !l2 ? r + s2 : nb1;
    // nt is the current fire time; a non-increasing successor fires one cycle later instead.
    assign nnt = (nr <= nt) ? nt + TW'(1) : nr;
    assign cd2 = !en_q ? d2 : l2 ? '0 : d2 + CW'(1);
    assign cd1 = !en_q ? d1 : !l2 ? d1 : l1 ? '0 : d1 + CW'(1);
    assign cd0 = (en_q && l2 && l1) ? d0 + CW'(1) : d0;
    assign cb0 = en_q ? nb0 : b0;
    assign cb1 = en_q ? nb1 : b1;
    assign cr = en_q ? nr : r;
    assign cnt = en_q ? nnt : nt;
    assign tn = t + TW'(!stl);
    assign active = state == WAIT || state == RUN;
    assign fire = !bus.stall && tn == cnt;
    assign empty = bus.cfg_extent[0] == '0 || bus.cfg_extent[1] == '0 || bus.cfg_extent[2] == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ext    <= '0;
            str    <= '0;
            {d0, d1, d2} <= '0;
            {t, nt, r, b0, b1} <= '0;
            stl    <= 1'b0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
            vars_q <= '0;
        end else if (bus.flush) begin
            state  <= empty ? DONE : WAIT;
            ext    <= bus.cfg_extent;
            str    <= bus.cfg_stride;
            {d0, d1, d2} <= '0;
            t      <= '0;
            nt     <= bus.cfg_start;
            r      <= bus.cfg_start;
            b0     <= bus.cfg_start;
            b1     <= bus.cfg_start;
            stl    <= bus.stall;
            en_q   <= !empty && !bus.stall && bus.cfg_start == '0;
            done_q <= empty;
            vars_q <= '0;
        end else if (active && en_q && last) begin
            state  <= DONE;
            en_q   <= 1'b0;
            done_q <= 1'b1;
        end else if (active) begin
            state  <= en_q ? RUN : state;
            {d0, d1, d2} <= {cd0, cd1, cd2};
            b0     <= cb0;
            b1     <= cb1;
            r      <= cr;
            nt     <= cnt;
            t      <= tn;
            stl    <= bus.stall;
            en_q   <= fire;
            vars_q <= fire ? {cd0, cd1, cd2} : vars_q;
        end
    end

    assign bus.en = en_q;
    assign bus.done = done_q;
    assign bus.ctrl_vars = vars_q;
endmodule

// File: tb/tb_ub_affine_sched_ctrl.sv
// tb_ub_affine_sched_ctrl: scoreboard bench; stimulus queues expected fires, monitor pops on en.
module tb_ub_affine_sched_ctrl;
    localparam int CW = 16;
    localparam int TW = 32;

    typedef struct {
        int              c;
        logic [3*CW-1:0] v;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ub_affine_sched_ctrl_if #(.CW(CW), .TW(TW)) bus();
    ub_affine_sched_ctrl #(.CW(CW), .TW(TW)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));

    ev_t q[$];
    ev_t em;
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  exp_done = -1;
    bit  fl = 1'b0;
    bit  dseen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int c, input int a, input int b, input int d);
        ev_t e;
        e.c = c;
        e.v = {CW'(a), CW'(b), CW'(d)};
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        fl <= bus.flush;
        cyc <= bus.flush ? 0 : cyc + 1;
    end

    always @(negedge clk) begin
        if (fl) dseen = 1'b0;
        if (bus.en) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_en: cycle %0d vars %0h, expected no en", cyc, bus.ctrl_vars);
            end else begin
                em = q.pop_front();
                chk("en_cycle", 64'(cyc), 64'(em.c));
                chk("ctrl_vars", 64'(bus.ctrl_vars), 64'(em.v));
            end
        end
        if (bus.done && !dseen) begin
            dseen = 1'b1;
            chk("done_cycle", 64'(cyc), 64'(exp_done));
        end
    end

    task automatic run(input int e0, input int e1, input int e2,
                       input int s0, input int s1, input int s2, input int st);
        @(negedge clk);
        bus.cfg_extent[0] = CW'(e0);
        bus.cfg_extent[1] = CW'(e1);
        bus.cfg_extent[2] = CW'(e2);
        bus.cfg_stride[0] = CW'(s0);
        bus.cfg_stride[1] = CW'(s1);
        bus.cfg_stride[2] = CW'(s2);
        bus.cfg_start = TW'(st);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.cfg_extent = '0;
        bus.cfg_stride = '0;
        bus.cfg_start = '0;
    endtask

    task automatic settle(input string name, input logic exp_dn);
        repeat (25) @(negedge clk);
        chk({name, "_missing_en"}, 64'(q.size()), 64'(0));
        chk({name, "_done"}, 64'(bus.done), 64'(exp_dn));
        q.delete();
    endtask

    initial begin
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        bus.cfg_start = '0;
        bus.cfg_extent = '0;
        bus.cfg_stride = '0;
        #12;
        chk("rst_en", 64'(bus.en), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_vars", 64'(bus.ctrl_vars), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_done", 64'(bus.done), 64'(0));

        for (int i = 0; i < 16; i++) push(2 + i, 0, i / 4, i % 4);
        exp_done = 18;
        run(1, 4, 4, 0, 4, 1, 2);
        settle("t1", 1'b1);

        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 3; b++) push(10 * a + 3 * b, 0, a, b);
        exp_done = 17;
        run(1, 2, 3, 0, 10, 3, 0);
        settle("t2", 1'b1);

        for (int i = 0; i < 3; i++) push(5 + i, 0, 0, i);
        exp_done = 8;
        run(1, 1, 3, 0, 0, 0, 5);
        settle("t3", 1'b1);

        exp_done = 0;
        run(1, 4, 0, 0, 4, 1, 2);
        settle("t4", 1'b1);

        for (int i = 0; i < 16; i++) push(i < 4 ? 2 + i : 5 + i, 0, i / 4, i % 4);
        exp_done = 21;
        run(1, 4, 4, 0, 4, 1, 2);
        repeat (5) @(negedge clk);
        bus.stall = 1'b1;
        repeat (3) @(negedge clk);
        bus.stall = 1'b0;
        settle("t5", 1'b1);

        for (int i = 0; i < 8; i++) push(2 + i, 0, i / 4, i % 4);
        for (int i = 0; i < 16; i++) push(2 + i, 0, i / 4, i % 4);
        exp_done = 18;
        run(1, 4, 4, 0, 4, 1, 2);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        bus.cfg_extent[0] = CW'(1);
        bus.cfg_extent[1] = CW'(4);
        bus.cfg_extent[2] = CW'(4);
        bus.cfg_stride[1] = CW'(4);
        bus.cfg_stride[2] = CW'(1);
        bus.cfg_start = TW'(2);
        @(negedge clk);
        bus.flush = 1'b0;
        settle("t6", 1'b1);

        for (int i = 0; i < 4; i++) push(2 + i, 0, 0, i);
        exp_done = -1;
        run(1, 4, 4, 0, 4, 1, 2);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_en", 64'(bus.en), 64'(0));
        chk("midrst_vars", 64'(bus.ctrl_vars), 64'(0));
        chk("midrst_done", 64'(bus.done), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        settle("t7", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
